// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// One operand bit per cycle; results land in HI/LO only on completion.
module muldiv_unit #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] opd;

  logic             is_md;
  logic             sgn;
  logic             sa;
  logic             sb;
  logic             bz;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;

  assign is_md = ~op[2];
  assign sgn   = SIGNED_EN && !op[0];
  assign sa    = sgn & a[WIDTH-1];
  assign sb    = sgn & b[WIDTH-1];
  assign ma    = sa ? -a : a;
  assign mb    = sb ? -b : b;
  assign bz    = (b == '0);

  logic [WIDTH:0]     m_sum;
  logic [WIDTH:0]     d_try;
  logic [WIDTH:0]     d_acc;
  logic               d_ge;
  logic [WIDTH:0]     acc_n;
  logic [WIDTH-1:0]   sh_n;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  // mul: acc:sh shifts right; div: acc:sh shifts left
  assign m_sum = sh[0] ? acc + {1'b0, opd} : acc;
  assign d_try = {acc[WIDTH-1:0], sh[WIDTH-1]};
  assign d_ge  = d_try >= {1'b0, opd};
  assign d_acc = d_ge ? d_try - {1'b0, opd} : d_try;

  assign acc_n = is_div ? d_acc
                        : {1'b0, m_sum[WIDTH:1]};
  assign sh_n  = is_div ? {sh[WIDTH-2:0], d_ge}
                        : {m_sum[0], sh[WIDTH-1:1]};

  assign prod     = {acc_n[WIDTH-1:0], sh_n};
  assign prod_fix = neg_q ? -prod : prod;
  assign q_fix    = neg_q ? -sh_n : sh_n;
  assign r_fix    = neg_r ? -acc_n[WIDTH-1:0]
                          : acc_n[WIDTH-1:0];

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc    <= '0;
      sh     <= '0;
      opd    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            unique case (1'b1)
              is_md: begin
                state  <= RUN;
                cnt    <= '0;
                acc    <= '0;
                is_div <= op[1];
                if (!op[1]) begin
                  opd   <= ma;
                  sh    <= mb;
                  neg_q <= sa ^ sb;
                  neg_r <= 1'b0;
                end else if (bz) begin
                  // unsigned pass gives q=all ones, r=a
                  opd   <= '0;
                  sh    <= a;
                  neg_q <= 1'b0;
                  neg_r <= 1'b0;
                end else begin
                  opd   <= mb;
                  sh    <= ma;
                  neg_q <= sa ^ sb;
                  neg_r <= sa;
                end
              end
              op == 3'b100: hi <= a;
              op == 3'b101: lo <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc <= acc_n;
            sh  <= sh_n;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state <= IDLE;
              done  <= 1'b1;
              if (is_div) begin
                hi <= r_fix;
                lo <= q_fix;
              end else begin
                hi <= prod_fix[2*WIDTH-1:WIDTH];
                lo <= prod_fix[WIDTH-1:0];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit.
// Reference results come from plain integer arithmetic.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  muldiv_unit #(
    .WIDTH(32),
    .SIGNED_EN(1'b1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .flush(flush),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // returns {hi, lo}
  function automatic logic [63:0] ref_model(
    input logic [2:0] o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    longint      p;
    int          sx;
    int          sy;
    logic [31:0] q;
    logic [31:0] r;
    sx = x;
    sy = y;
    if (o == 3'd0) begin
      p = longint'(sx) * longint'(sy);
      return p;
    end
    if (o == 3'd1)
      return {32'b0, x} * {32'b0, y};
    if (y == 0)
      return {x, 32'hFFFF_FFFF};
    if (o == 3'd2) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
        return {32'h0, 32'h8000_0000};
      q = sx / sy;
      r = sx % sy;
    end else begin
      q = x / y;
      r = x % y;
    end
    return {r, q};
  endfunction

  task automatic do_op(input logic [2:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y);
    logic [63:0] r;
    int n;
    r = ref_model(o, x, y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    tick();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    check("busy_cycles", 64'(n), 64'd32);
    check("done", {63'b0, done}, 64'd1);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    check("hi", {32'b0, hi}, {32'b0, exp_hi});
    check("lo", {32'b0, lo}, {32'b0, exp_lo});
    tick();
    check("done_pulse", {63'b0, done}, 64'd0);
  endtask

  task automatic do_mt(input logic [2:0] o,
                       input logic [31:0] x);
    start = 1'b1;
    op = o;
    a = x;
    tick();
    start = 1'b0;
    if (o == 3'd4) exp_hi = x;
    if (o == 3'd5) exp_lo = x;
    check("mt_busy", {63'b0, busy}, 64'd0);
    check("mt_done", {63'b0, done}, 64'd0);
    check("mt_hi", {32'b0, hi}, {32'b0, exp_hi});
    check("mt_lo", {32'b0, lo}, {32'b0, exp_lo});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    start = 1'b0;
    op = 3'd0;
    a = '0;
    b = '0;
    flush = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    tick();
    tick();
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    rst = 1'b1;

    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(3'd0, 32'hFFFF_FFFD, 32'd5);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'd3, 32'd100, 32'd0);
    do_op(3'd2, 32'hFFFF_FF9C, 32'd0);
    do_op(3'd2, 32'd7, 32'hFFFF_FFFE);

    for (int i = 0; i < 40; i++)
      do_op(3'($urandom_range(0, 3)), pick(), pick());

    // flush mid-divide, start while busy ignored
    do_mt(3'd4, 32'h1234);
    do_mt(3'd5, 32'h55);
    start = 1'b1;
    op = 3'd3;
    a = 32'd9;
    b = 32'd2;
    tick();
    start = 1'b0;
    check("div_busy", {63'b0, busy}, 64'd1);
    tick();
    tick();
    start = 1'b1;
    op = 3'd5;
    a = 32'hAA;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("run_done", {63'b0, done}, 64'd0);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_busy", {63'b0, busy}, 64'd0);
    check("fl_done", {63'b0, done}, 64'd0);
    check("fl_hi", {32'b0, hi}, 64'h1234);
    check("fl_lo", {32'b0, lo}, 64'h55);
    for (int i = 0; i < 40; i++) begin
      tick();
      check("fl_quiet", {63'b0, done}, 64'd0);
    end

    // flush beats start at the same edge
    flush = 1'b1;
    start = 1'b1;
    op = 3'd4;
    a = 32'hDEAD;
    tick();
    check("fs_hi", {32'b0, hi}, 64'h1234);
    op = 3'd0;
    tick();
    check("fs_busy", {63'b0, busy}, 64'd0);
    flush = 1'b0;
    op = 3'd6;
    tick();
    start = 1'b0;
    check("nop_busy", {63'b0, busy}, 64'd0);
    check("nop_hi", {32'b0, hi}, 64'h1234);
    check("nop_lo", {32'b0, lo}, 64'h55);

    // reset in the middle of a multiply
    start = 1'b1;
    op = 3'd0;
    a = 32'hFFFF_FFFD;
    b = 32'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    #2;
    rst = 1'b0;
    #1;
    check("ar_busy", {63'b0, busy}, 64'd0);
    check("ar_done", {63'b0, done}, 64'd0);
    check("ar_hi", {32'b0, hi}, 64'd0);
    check("ar_lo", {32'b0, lo}, 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    tick();
    rst = 1'b1;
    do_op(3'd1, 32'd2, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width and HI/LO width; legal values are even numbers >= 4.
REQ-002 SHALL have parameter SIGNED_EN, default 1: 1 enables the signed ops (MULT, DIV); 0 executes them as MULTU/DIVU.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request; sampled at a rising edge only when busy=0.
REQ-007 op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op.
REQ-008 a  input  WIDTH  multiplicand, dividend, or MTHI/MTLO data.
REQ-009 b  input  WIDTH  multiplier or divisor.
REQ-010 flush  input  1  abort the operation in progress (pipeline flush or exception).
REQ-011 busy  output  1  operation in progress; drives the pipeline stall for MFHI/MFLO and new mul/div.
REQ-012 done  output  1  one-cycle pulse: HI/LO just updated by a mul/div.
REQ-013 hi  output  WIDTH  HI register.
REQ-014 lo  output  WIDTH  LO register.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and RUN, with an internal cycle counter of width clog2(WIDTH)+1.
REQ-016 IDLE->RUN SHALL occur when start=1, op is one of 000-011, and flush=0 at a rising edge (edge E0); busy=1 from E0.
REQ-017 In RUN, the unit SHALL process one operand bit per cycle: shift-add for multiply, restoring subtract for divide.
REQ-018 At edge E_WIDTH the unit SHALL write hi/lo, return to IDLE with busy=0, and assert done=1 for exactly the following cycle.
REQ-019 busy SHALL therefore be high for exactly WIDTH cycles per mul/div.
REQ-020 Multiply SHALL produce {hi,lo} = the full 2*WIDTH product.
REQ-021 Signed multiply SHALL multiply the magnitudes and negate the 2*WIDTH result when the operand signs differ.
REQ-022 Divide SHALL set lo=quotient and hi=remainder.
REQ-023 Signed divide SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-024 Signed most-negative/-1 SHALL give lo=most-negative (wrap) and hi=0.
REQ-025 Divide by zero SHALL complete normally after WIDTH cycles with lo=all ones and hi=a (unsigned view).
REQ-026 The divide-by-zero result SHALL be identical for DIV and DIVU.
REQ-027 Operands SHALL be captured at E0; a/b changes during RUN SHALL have no effect.
REQ-028 MTHI/MTLO with busy=0 SHALL write a to hi or lo at that edge and leave busy=0 and done=0.
REQ-029 start while busy=1 SHALL be ignored for every op; the issuing stage is responsible for stalling.
REQ-030 flush=1 in RUN SHALL return the FSM to IDLE at the next edge with busy=0 and no done pulse.
REQ-031 On flush, hi/lo SHALL retain their pre-operation values.
REQ-032 flush and start at the same edge SHALL give flush priority: nothing starts, including MTHI/MTLO.
REQ-033 No partial result SHALL ever be visible on hi/lo.

Reset
REQ-034 While rst=0, asynchronously: state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0.
REQ-035 Reset during RUN SHALL abort the operation without a done pulse.
REQ-036 The first start SHALL be honoured at the first rising edge after rst deasserts.

Verification (WIDTH=32, SIGNED_EN=1)
REQ-037 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high for 32 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001.
REQ-038 MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-039 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-040 DIVU a=100, b=0 -> after 32 cycles lo=0xFFFFFFFF, hi=0x00000064, done=1.
REQ-041 MTHI 0x1234 then DIVU 9/2 with MTLO 0xAA issued at cycle 3 (ignored) and flush at cycle 10 -> busy=0 at next edge, no done, hi=0x1234, lo unchanged.
REQ-042 rst=0 at cycle 15 of a MULT -> busy, done, hi, lo read 0 immediately; MULTU 2*3 started after release -> lo=6, hi=0.
